ifu_fetch: RTL and testbench

Instruction fetch unit directly upstream of the single-cycle core datapath.
- Generates sequential fetch PCs from `START_ADDR`.
- Issues word requests over a grant/response instruction-memory handshake.
- Buffers returned instructions with their PCs and presents them to the core over valid/ready.
- Accepts PC redirects (branch/jump `dnpc`) from the execute stage and flushes stale fetches.

---
 rtl/ifu_pkg.sv | 38 +++
 rtl/ifu_fifo.sv | 77 +++++++
 rtl/ifu_fetch.sv | 219 +++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               Holds the default PC width and reset PC, the canonical NOP
//               word, the output-FIFO entry type and a clog2 helper used for
//               counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int          XLEN       = 64;
    localparam logic [63:0] START_ADDR = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;   // addi x0, x0, 0

    // One delivered instruction: its PC, the word itself, and a flag marking
    // a synthetic NOP that stands in for a misaligned fetch PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            misalign;
    } ifu_entry_t;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fifo
// Description : Synchronous FIFO with a parameterised entry type.
//               The head entry is read straight out of registered storage,
//               so head/empty/full/count carry no combinational path from
//               the push/pop/flush inputs. Push while full is accepted when
//               a pop happens in the same cycle. Flush empties the FIFO and
//               takes priority over push and pop.
// Ports       : clk, rst (async, active-low)
//               flush, push/din, pop   - control and write data
//               head, full, empty, count - status and read data
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 2,                  // power of two, >= 2
    parameter type T_ENTRY = logic [63:0],
    parameter int  CNT_W   = 2                   // clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  T_ENTRY           din,
    input  logic             pop,
    output T_ENTRY           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_ptr_w = clog2(DEPTH);

    T_ENTRY               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    // When full, the slot being written is the one being popped this cycle.
    assign w_do_pop  = pop  & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : ifu_fifo
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit. Generates sequential word fetch PCs,
//               issues them over a request/grant instruction-memory port,
//               tags each grant with its PC, and buffers returned words for
//               the core on a valid/ready interface. Redirects load a new PC,
//               clear buffered instructions and discard every response still
//               owed for requests issued before the redirect.
// Macro       : IFU_MISALIGN_CHK_EN - adds inst_misalign; a misaligned fetch
//               PC issues no request and instead delivers one NOP marked
//               misaligned, then stalls until the next redirect.
// Ports       : clk, rst (async, active-low)
//               redirect_valid/redirect_pc      - PC redirect from execute
//               imem_req/imem_addr/imem_gnt     - fetch request handshake
//               imem_rvalid/imem_rdata          - in-order fetch responses
//               inst_valid/inst/inst_pc/inst_ready - instruction to core
//               inst_misalign (macro only)      - synthetic misalign NOP
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN       = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0] START_ADDR = ifu_pkg::START_ADDR,
    parameter int              DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
`ifdef IFU_MISALIGN_CHK_EN
    output logic            inst_misalign,
`endif
    input  logic            inst_ready
);

    localparam int                 c_cnt_w = clog2(DEPTH + 1);
    localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(DEPTH);

    logic                 r_started;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [c_cnt_w-1:0]   r_drop_cnt;

    logic                 w_tag_push;
    logic                 w_tag_pop;
    logic [XLEN-1:0]      w_tag_head;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic [c_cnt_w-1:0]   w_tag_count;

    logic                 w_out_push;
    logic                 w_out_pop;
    ifu_entry_t           w_out_din;
    ifu_entry_t           w_out_head;
    logic                 w_out_full;
    logic                 w_out_empty;
    logic [c_cnt_w-1:0]   w_out_count;

    logic [c_cnt_w:0]     w_total;
    logic [c_cnt_w:0]     w_live;
    logic                 w_grant;
    logic                 w_zero_lat;
    logic                 w_rsp_hit;
    logic                 w_rsp_keep;
    logic [XLEN-1:0]      w_rsp_pc;
    logic [c_cnt_w-1:0]   w_outstanding_next;
    logic                 w_misaligned;
    logic                 w_mis_push;

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    assign w_total  = {1'b0, w_out_count} + {1'b0, w_tag_count};
    assign w_live   = w_total - {1'b0, r_drop_cnt};

    assign imem_req  = r_started & (w_live < c_depth) & (w_total < c_depth) & ~w_misaligned;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req & imem_gnt;

    // A same-cycle grant and response with nothing else in flight is a
    // zero-latency return of the current request: it never enters the tag
    // queue and its PC is the current fetch PC.
    assign w_zero_lat = w_grant & imem_rvalid & w_tag_empty;
    assign w_tag_push = w_grant & ~w_zero_lat & ~w_tag_full;
    assign w_tag_pop  = imem_rvalid & ~w_tag_empty;
    assign w_rsp_hit  = w_tag_pop | w_zero_lat;
    assign w_rsp_pc   = w_tag_empty ? r_fetch_pc : w_tag_head;

    // Requests still owed a response after this edge; on a redirect all of
    // them are stale, including one granted in the redirect cycle itself.
    assign w_outstanding_next = w_tag_count + c_cnt_w'(w_tag_push) - c_cnt_w'(w_tag_pop);

    assign w_rsp_keep = w_rsp_hit & ~redirect_valid & (r_drop_cnt == '0);

    // ------------------------------------------------------------------
    // Output FIFO write side
    // ------------------------------------------------------------------
    assign w_out_pop  = ~w_out_empty & inst_ready;
    assign w_out_push = (w_rsp_keep | w_mis_push) & (~w_out_full | w_out_pop);

    always_comb begin
        w_out_din          = '0;
        w_out_din.pc       = w_rsp_pc;
        w_out_din.inst     = imem_rdata;
        w_out_din.misalign = 1'b0;
        if (w_mis_push) begin
            w_out_din.pc       = r_fetch_pc;
            w_out_din.inst     = NOP_INST;
            w_out_din.misalign = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC, start-up and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_started  <= 1'b0;
            r_fetch_pc <= START_ADDR;
            r_drop_cnt <= '0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_drop_cnt <= w_outstanding_next;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp_hit && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Misaligned-PC handling
    // ------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHK_EN
    logic r_mis_done;

    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    // Wait for every live fetch to drain so the marker lands in program order.
    assign w_mis_push   = w_misaligned & ~r_mis_done & (w_live == '0) & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis_done <= 1'b0;
        end else if (redirect_valid) begin
            r_mis_done <= 1'b0;
        end else if (w_mis_push) begin
            r_mis_done <= 1'b1;
        end
    end

    assign inst_misalign = ~w_out_empty & w_out_head.misalign;
`else
    logic w_unused_misalign;

    assign w_misaligned      = 1'b0;
    assign w_mis_push        = 1'b0;
    assign w_unused_misalign = w_out_head.misalign;
`endif

    // ------------------------------------------------------------------
    // Queues
    // ------------------------------------------------------------------
    // Tag queue: PCs of granted requests; stale tags pop with their
    // discarded responses, so it is never flushed.
    ifu_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (logic [XLEN-1:0]),
        .CNT_W   (c_cnt_w)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (w_tag_push),
        .din   (r_fetch_pc),
        .pop   (w_tag_pop),
        .head  (w_tag_head),
        .full  (w_tag_full),
        .empty (w_tag_empty),
        .count (w_tag_count)
    );

    ifu_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (ifu_entry_t),
        .CNT_W   (c_cnt_w)
    ) u_out_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_out_push),
        .din   (w_out_din),
        .pop   (w_out_pop),
        .head  (w_out_head),
        .full  (w_out_full),
        .empty (w_out_empty),
        .count (w_out_count)
    );

    assign inst_valid = ~w_out_empty;
    assign inst       = w_out_empty ? '0 : w_out_head.inst;
    assign inst_pc    = w_out_empty ? '0 : w_out_head.pc;

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch (DEPTH = 2). A streaming
//               and backpressure table is applied cycle by cycle, followed by
//               hand-written redirect, simultaneous-event, back-to-back
//               redirect, optional misalign and mid-stream reset sequences.
//               Memory data is a fixed function of the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
`ifdef IFU_MISALIGN_CHK_EN
    logic        inst_misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] mq[$];          // addresses granted, awaiting a response
    logic [63:0] h_pc;

    always #5 clk = ~clk;

    ifu_fetch #(
        .XLEN       (64),
        .START_ADDR (B),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
`ifdef IFU_MISALIGN_CHK_EN
        .inst_misalign  (inst_misalign),
`endif
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic        g;
        logic        rv;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        v;
        logic [63:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic g, input logic rv, input logic rdy, input logic req,
                       input logic [31:0] aoff, input logic v, input logic [31:0] poff);
        vec_t r;
        r.g    = g;
        r.rv   = rv;
        r.rdy  = rdy;
        r.req  = req;
        r.addr = B + {32'h0, aoff};
        r.v    = v;
        r.pc   = B + {32'h0, poff};
        tbl.push_back(r);
    endtask

    // One clock cycle: drive just after the rising edge, sample at the
    // falling edge. zl = zero-latency response to the current request.
    task automatic cyc(input logic g, input logic rv, input logic zl, input logic rdy,
                       input logic rd, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        imem_gnt       = g;
        imem_rvalid    = rv;
        inst_ready     = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (rv) imem_rdata = zl ? mem_word(imem_addr) : ((mq.size() > 0) ? mem_word(mq[0]) : 32'h0);
        else    imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (rv && !zl && (mq.size() > 0)) void'(mq.pop_front());
        if (imem_req && g && !zl) mq.push_back(imem_addr);
    endtask

    task automatic expect_out(input string nm, input logic req, input logic [63:0] addr,
                              input logic v, input logic [63:0] pc);
        chk1({nm, " imem_req"}, imem_req, req);
        chk64({nm, " imem_addr"}, imem_addr, addr);
        chk1({nm, " inst_valid"}, inst_valid, v);
        if (v) begin
            chk64({nm, " inst_pc"}, inst_pc, pc);
            chk32({nm, " inst"}, inst, mem_word(pc));
        end
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;

        // Streaming (memory latency 1), then backpressure and drain.
        add(1,0,1, 1,32'h00, 0,32'h00);
        add(1,1,1, 1,32'h04, 0,32'h00);
        add(1,1,1, 0,32'h08, 1,32'h00);
        add(1,0,1, 1,32'h08, 1,32'h04);
        add(1,1,1, 1,32'h0C, 0,32'h00);
        add(1,1,1, 0,32'h10, 1,32'h08);
        add(0,0,1, 1,32'h10, 1,32'h0C);
        add(1,0,0, 1,32'h10, 0,32'h00);
        add(1,1,0, 1,32'h14, 0,32'h00);
        add(1,1,0, 0,32'h18, 1,32'h10);
        add(1,0,0, 0,32'h18, 1,32'h10);
        add(1,0,0, 0,32'h18, 1,32'h10);
        add(1,0,1, 0,32'h18, 1,32'h10);
        add(1,0,1, 1,32'h18, 1,32'h14);
        add(1,1,1, 1,32'h1C, 0,32'h00);
        add(0,1,1, 0,32'h20, 1,32'h18);
        add(0,0,1, 1,32'h20, 1,32'h1C);
        add(0,0,1, 1,32'h20, 0,32'h00);

        // Reset held with grant asserted.
        repeat (3) begin
            @(negedge clk);
            chk1("reset imem_req", imem_req, 1'b0);
            chk1("reset inst_valid", inst_valid, 1'b0);
            chk32("reset inst", inst, 32'h0);
            chk64("reset inst_pc", inst_pc, 64'h0);
            chk64("reset imem_addr", imem_addr, B);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("release imem_req", imem_req, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].g, tbl[i].rv, 1'b0, tbl[i].rdy, 1'b0, 64'h0);
            expect_out($sformatf("stream%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc);
        end

        // Redirect with two requests outstanding, 3-cycle memory latency.
        cyc(1,0,0,1,0,64'h0);      expect_out("rd0",  1, B+64'h20,   0, 64'h0);
        cyc(1,0,0,1,0,64'h0);      expect_out("rd1",  1, B+64'h24,   0, 64'h0);
        cyc(1,0,0,1,1,B+64'h1000); expect_out("rd2",  0, B+64'h28,   0, 64'h0);
        cyc(1,1,0,1,0,64'h0);      expect_out("rd3",  0, B+64'h1000, 0, 64'h0);
        cyc(1,1,0,1,0,64'h0);      expect_out("rd4",  1, B+64'h1000, 0, 64'h0);
        cyc(1,0,0,1,0,64'h0);      expect_out("rd5",  1, B+64'h1004, 0, 64'h0);
        cyc(1,0,0,1,0,64'h0);      expect_out("rd6",  0, B+64'h1008, 0, 64'h0);
        cyc(1,1,0,1,0,64'h0);      expect_out("rd7",  0, B+64'h1008, 0, 64'h0);
        cyc(1,1,0,1,0,64'h0);      expect_out("rd8",  0, B+64'h1008, 1, B+64'h1000);
        cyc(1,0,0,1,0,64'h0);      expect_out("rd9",  1, B+64'h1008, 1, B+64'h1004);
        cyc(0,1,0,1,0,64'h0);      expect_out("rd10", 1, B+64'h100C, 0, 64'h0);
        cyc(0,0,0,1,0,64'h0);      expect_out("rd11", 1, B+64'h100C, 1, B+64'h1008);

        // Redirect coinciding with a grant, a response and a handshake.
        cyc(1,1,1,0,0,64'h0);      expect_out("sim0", 1, B+64'h100C, 0, 64'h0);
        cyc(1,1,1,1,1,B+64'h2000); expect_out("sim1", 1, B+64'h1010, 1, B+64'h100C);
        cyc(0,0,0,1,0,64'h0);      expect_out("sim2", 1, B+64'h2000, 0, 64'h0);
        cyc(1,1,1,1,0,64'h0);      expect_out("sim3", 1, B+64'h2000, 0, 64'h0);
        cyc(0,0,0,1,0,64'h0);      expect_out("sim4", 1, B+64'h2004, 1, B+64'h2000);

        // Back-to-back redirects; the grant in the first one counts as stale.
        cyc(1,0,0,1,0,64'h0);      expect_out("b2b0", 1, B+64'h2004, 0, 64'h0);
        cyc(1,0,0,1,1,B+64'h3000); expect_out("b2b1", 1, B+64'h2008, 0, 64'h0);
        cyc(0,1,0,1,1,B+64'h4000); expect_out("b2b2", 0, B+64'h3000, 0, 64'h0);
        cyc(0,1,0,1,0,64'h0);      expect_out("b2b3", 1, B+64'h4000, 0, 64'h0);
        cyc(1,0,0,1,0,64'h0);      expect_out("b2b4", 1, B+64'h4000, 0, 64'h0);
        cyc(0,1,0,1,0,64'h0);      expect_out("b2b5", 1, B+64'h4004, 0, 64'h0);
        cyc(0,0,0,1,0,64'h0);      expect_out("b2b6", 1, B+64'h4004, 1, B+64'h4000);

`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned redirect: one marked NOP, then stall until redirect.
        cyc(0,0,0,1,1,B+64'h2);    expect_out("mis0", 1, B+64'h4004, 0, 64'h0);
        cyc(1,0,0,0,0,64'h0);      expect_out("mis1", 0, B+64'h2, 0, 64'h0);
        cyc(1,0,0,0,0,64'h0);
        chk1("mis2 imem_req", imem_req, 1'b0);
        chk1("mis2 inst_valid", inst_valid, 1'b1);
        chk64("mis2 inst_pc", inst_pc, B+64'h2);
        chk32("mis2 inst", inst, 32'h0000_0013);
        chk1("mis2 inst_misalign", inst_misalign, 1'b1);
        cyc(1,0,0,1,0,64'h0);
        chk1("mis3 imem_req", imem_req, 1'b0);
        chk1("mis3 inst_valid", inst_valid, 1'b1);
        cyc(1,0,0,1,0,64'h0);      expect_out("mis4", 0, B+64'h2, 0, 64'h0);
        chk1("mis4 inst_misalign", inst_misalign, 1'b0);
        cyc(0,0,0,1,1,B+64'h100);  expect_out("mis5", 0, B+64'h2, 0, 64'h0);
        cyc(0,0,0,1,0,64'h0);      expect_out("mis6", 1, B+64'h100, 0, 64'h0);
        h_pc = B + 64'h100;
`else
        h_pc = B + 64'h4004;
`endif

        // Asynchronous reset in the middle of a cycle with an entry buffered.
        cyc(1,1,1,0,0,64'h0);      expect_out("mid0", 1, h_pc, 0, 64'h0);
        cyc(0,0,0,0,0,64'h0);      expect_out("mid1", 1, h_pc + 64'h4, 1, h_pc);
        #2;
        rst = 1'b0;
        #1;
        chk1("midrst imem_req", imem_req, 1'b0);
        chk1("midrst inst_valid", inst_valid, 1'b0);
        chk32("midrst inst", inst, 32'h0);
        chk64("midrst inst_pc", inst_pc, 64'h0);
        chk64("midrst imem_addr", imem_addr, B);
`ifdef IFU_MISALIGN_CHK_EN
        chk1("midrst inst_misalign", inst_misalign, 1'b0);
`endif
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ifu_fetch
`default_nettype wire
